apb_slave_mem_ws: RTL and testbench
===================================

# apb_slave_mem_ws

Parametrised APB4 completer with a word-addressed, byte-strobed internal memory, programmable wait states, and full address, alignment, strobe and protection error checking. It is the next-generation memory slave behind the AXI-APB bridge, one instance per APB slave slot. It replaces the fixed 32-bit zero-wait slave with a registered, state-machine-driven design.

## Interface
- ADDR_WIDTH, 32: PADDR width.
- DATA_WIDTH, 32: PWDATA/PRDATA width; legal values 32 or 64. STRB_W = DATA_WIDTH/8.
- MEM_DEPTH, 1024: number of DATA_WIDTH-bit words; power of two.
- BASE_ADDR, 32'h0000_3000: first byte address of the slave window; aligned to MEM_DEPTH*STRB_W.
- WAIT_STATES, 0: access-phase cycles with PREADY low before completion, 0..15.
- SECURE_ONLY, 0: when 1, non-secure accesses (PPROT[1]=1) are errors.
- PCLK  in  1  APB clock; all logic on the rising edge.
- PRESETn  in  1  synchronous, active-low reset.
- PSEL  in  1  select.
- PENABLE  in  1  access phase.
- PWRITE  in  1  1 = write.
- PPROT  in  3  protection; only bit 1 is checked.
- PADDR  in  ADDR_WIDTH  byte address.
- PWDATA  in  DATA_WIDTH  write data.
- PSTRB  in  STRB_W  write byte lanes; must be all-zero on reads.
- PRDATA  out  DATA_WIDTH  read data.
- PREADY  out  1  transfer completion.
- PSLVERR  out  1  error, valid only with PREADY.

## Operation
- Window: BASE_ADDR to BASE_ADDR + MEM_DEPTH*STRB_W - 1. Word index = (PADDR - BASE_ADDR) >> log2(STRB_W).
- FSM states: IDLE and ACCESS.
- IDLE:
  - A setup cycle (PSEL=1, PENABLE=0) captures PADDR, PWRITE, PSTRB, PWDATA, PPROT and the error flag.
  - The same cycle loads wait counter = WAIT_STATES and moves to ACCESS.
  - On a read with no error, the same cycle latches mem[idx] into the read register.
- Error flag is set if any of these hold:
  - PADDR is outside the window.
  - PADDR low log2(STRB_W) bits are non-zero.
  - Read with PSTRB != 0.
  - SECURE_ONLY=1 and PPROT[1]=1.
- ACCESS:
  - Counter decrements each cycle while non-zero.
  - PREADY = (state==ACCESS && counter==0), decoded from registers only.
  - On the PREADY cycle's edge: if write and no error, update each byte lane i of mem[idx] where captured PSTRB[i]=1. Return to IDLE.
  - If PSEL=0 in any ACCESS cycle, abort: return to IDLE, no memory write, no PREADY pulse.
- Errored transfers never modify memory.
- PRDATA = read register only when PREADY=1, read, and no error; otherwise 0.
- PSLVERR = PREADY && error flag.
- Reset values:
  - State IDLE, counter 0, PREADY 0, PSLVERR 0, PRDATA 0.
  - Read register 0; all memory words cleared to 0.
- Write data is taken from the setup-cycle capture. PWDATA changing during wait states has no effect.

## Timing
- Setup in cycle T, access phase from T+1. PREADY is high in cycle T+1+WAIT_STATES, for exactly one cycle per transfer.
- WAIT_STATES=0 gives the standard 2-cycle APB transfer.
- Write data is visible to a read whose setup is at or after T+2+WAIT_STATES.
- Back-to-back: a new setup in the cycle after PREADY is accepted with no idle gap.
- PENABLE=1 while in IDLE, with no preceding setup, is ignored.
- Reset asserted mid-transfer: the next cycle is IDLE with all outputs 0 and the pending write dropped.
- Reset has priority over every other event in the same cycle.

## Test plan
- Write and read back at WAIT_STATES=0, DATA_WIDTH=32:
  - Stimulus: write 0x0000_3010 = 0xDEADBEEF with PSTRB=4'hF, then read 0x0000_3010 with PSTRB=0.
  - Response: PREADY at T+1 both times; PRDATA=0xDEADBEEF; PSLVERR=0.
- Partial strobes:
  - Stimulus: write 0x11223344 with PSTRB=4'b0101 over an existing 0xDEADBEEF, then read.
  - Response: PRDATA=0xDE22BE44.
- Wait states at WAIT_STATES=3:
  - Stimulus: read from a setup at T.
  - Response: PREADY low for T+1..T+3 and high only at T+4. Changing PWDATA during a write's wait states does not alter the stored value.
- Error cases (each gives PREADY with PSLVERR=1, PRDATA=0, memory unchanged):
  - Write to 0x0000_2FFC.
  - Write to 0x0000_3002 (misaligned).
  - Read with PSTRB=4'h1.
  - SECURE_ONLY=1 and PPROT=3'b010.
- Abort and reset mid-transfer:
  - Stimulus: drop PSEL during a WAIT_STATES=2 write.
  - Response: no PREADY and memory unchanged.
  - Stimulus: assert PRESETn=0 mid-transfer.
  - Response: all outputs 0 the next cycle and a subsequent read returns 0.
- DATA_WIDTH=64, MEM_DEPTH=16:
  - Stimulus: write 0x0123456789ABCDEF to the last word, BASE+0x78.
  - Response: it reads back correctly.
  - Stimulus: access BASE+0x80.
  - Response: PSLVERR=1.

Source files
------------

// File: rtl/apb_slave_mem_ws.sv
// APB4 completer with byte-strobed word memory, programmable wait states and
// address/alignment/strobe/protection error checking.
module apb_slave_mem_ws #(
    parameter int unsigned              ADDR_WIDTH  = 32,
    parameter int unsigned              DATA_WIDTH  = 32,
    parameter int unsigned              MEM_DEPTH   = 1024,
    parameter logic [ADDR_WIDTH-1:0]    BASE_ADDR   = 32'h0000_3000,
    parameter int unsigned              WAIT_STATES = 0,
    parameter bit                       SECURE_ONLY = 1'b0,
    localparam int unsigned             STRB_W      = DATA_WIDTH / 8
) (
    input  logic                  PCLK,
    input  logic                  PRESETn,
    input  logic                  PSEL,
    input  logic                  PENABLE,
    input  logic                  PWRITE,
    input  logic [2:0]            PPROT,
    input  logic [ADDR_WIDTH-1:0] PADDR,
    input  logic [DATA_WIDTH-1:0] PWDATA,
    input  logic [STRB_W-1:0]     PSTRB,
    output logic [DATA_WIDTH-1:0] PRDATA,
    output logic                  PREADY,
    output logic                  PSLVERR
);

    localparam int unsigned LSB  = $clog2(STRB_W);
    localparam int unsigned IDXW = $clog2(MEM_DEPTH);
    localparam logic [ADDR_WIDTH:0] WIN_BYTES = (ADDR_WIDTH + 1)'(MEM_DEPTH * STRB_W);

    typedef enum logic {
        S_IDLE,
        S_ACCESS
    } state_t;

    state_t                r_state;
    state_t                w_state_next;
    logic [3:0]            r_cnt;
    logic [IDXW-1:0]       r_idx;
    logic                  r_write;
    logic [STRB_W-1:0]     r_strb;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic                  r_err;
    logic [DATA_WIDTH-1:0] r_rdata;
    logic [DATA_WIDTH-1:0] r_mem [MEM_DEPTH];

    logic [ADDR_WIDTH-1:0] w_offset;
    logic [IDXW-1:0]       w_idx;
    logic                  w_in_win;
    logic                  w_err;
    logic                  w_setup;
    logic                  w_commit;
    logic [DATA_WIDTH-1:0] w_merged;
    logic                  w_unused_prot;

    assign w_offset = PADDR - BASE_ADDR;
    assign w_idx    = w_offset[LSB +: IDXW];
    assign w_in_win = (PADDR >= BASE_ADDR) && ({1'b0, w_offset} < WIN_BYTES);
    assign w_err    = !w_in_win
                   || (|PADDR[LSB-1:0])
                   || (!PWRITE && (|PSTRB))
                   || (SECURE_ONLY && PPROT[1]);

    // Only the non-secure bit participates in error checking.
    assign w_unused_prot = PPROT[2] ^ PPROT[0];

    always_comb begin
        w_state_next = r_state;
        w_setup      = 1'b0;
        w_commit     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (PSEL && !PENABLE) begin
                    w_setup      = 1'b1;
                    w_state_next = S_ACCESS;
                end
            end
            S_ACCESS: begin
                if (!PSEL) begin
                    w_state_next = S_IDLE;
                end else if (r_cnt == 4'd0) begin
                    w_state_next = S_IDLE;
                    w_commit     = r_write && !r_err;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    for (genvar g = 0; g < STRB_W; g++) begin : g_lane
        assign w_merged[g*8 +: 8] = r_strb[g] ? r_wdata[g*8 +: 8] : r_mem[r_idx][g*8 +: 8];
    end

    always_ff @(posedge PCLK) begin
        if (!PRESETn) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_idx   <= '0;
            r_write <= 1'b0;
            r_strb  <= '0;
            r_wdata <= '0;
            r_err   <= 1'b0;
            r_rdata <= '0;
            r_mem   <= '{default: '0};
        end else begin
            r_state <= w_state_next;
            if (w_setup) begin
                r_idx   <= w_idx;
                r_write <= PWRITE;
                r_strb  <= PSTRB;
                r_wdata <= PWDATA;
                r_err   <= w_err;
                r_cnt   <= 4'(WAIT_STATES);
                if (!PWRITE && !w_err) begin
                    r_rdata <= r_mem[w_idx];
                end
            end else if (r_state == S_ACCESS && r_cnt != 4'd0) begin
                r_cnt <= r_cnt - 4'd1;
            end
            if (w_commit) begin
                r_mem[r_idx] <= w_merged;
            end
        end
    end

    assign PREADY  = (r_state == S_ACCESS) && (r_cnt == 4'd0);
    assign PSLVERR = PREADY && r_err;
    assign PRDATA  = (PREADY && !r_write && !r_err) ? r_rdata : '0;

endmodule

// File: tb/tb_apb_slave_mem_ws.sv
// Directed bench: four apb_slave_mem_ws configurations sharing one APB bus,
// each with its own select and reset.
module tb_apb_slave_mem_ws;

    logic        clk;
    logic [3:0]  rstn;
    logic [3:0]  psel;
    logic        penable;
    logic        pwrite;
    logic [2:0]  pprot;
    logic [31:0] paddr;
    logic [63:0] pwdata;
    logic [7:0]  pstrb;
    logic [31:0] rd0, rd1, rd2;
    logic [63:0] rd3;
    logic [3:0]  rdy;
    logic [3:0]  err;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    apb_slave_mem_ws #(.DATA_WIDTH(32), .WAIT_STATES(0)) u_ws0 (
        .PCLK(clk), .PRESETn(rstn[0]), .PSEL(psel[0]), .PENABLE(penable),
        .PWRITE(pwrite), .PPROT(pprot), .PADDR(paddr), .PWDATA(pwdata[31:0]),
        .PSTRB(pstrb[3:0]), .PRDATA(rd0), .PREADY(rdy[0]), .PSLVERR(err[0]));

    apb_slave_mem_ws #(.DATA_WIDTH(32), .WAIT_STATES(3)) u_ws3 (
        .PCLK(clk), .PRESETn(rstn[1]), .PSEL(psel[1]), .PENABLE(penable),
        .PWRITE(pwrite), .PPROT(pprot), .PADDR(paddr), .PWDATA(pwdata[31:0]),
        .PSTRB(pstrb[3:0]), .PRDATA(rd1), .PREADY(rdy[1]), .PSLVERR(err[1]));

    apb_slave_mem_ws #(.DATA_WIDTH(32), .WAIT_STATES(2), .SECURE_ONLY(1'b1)) u_sec (
        .PCLK(clk), .PRESETn(rstn[2]), .PSEL(psel[2]), .PENABLE(penable),
        .PWRITE(pwrite), .PPROT(pprot), .PADDR(paddr), .PWDATA(pwdata[31:0]),
        .PSTRB(pstrb[3:0]), .PRDATA(rd2), .PREADY(rdy[2]), .PSLVERR(err[2]));

    apb_slave_mem_ws #(.DATA_WIDTH(64), .MEM_DEPTH(16), .WAIT_STATES(0)) u_w64 (
        .PCLK(clk), .PRESETn(rstn[3]), .PSEL(psel[3]), .PENABLE(penable),
        .PWRITE(pwrite), .PPROT(pprot), .PADDR(paddr), .PWDATA(pwdata),
        .PSTRB(pstrb), .PRDATA(rd3), .PREADY(rdy[3]), .PSLVERR(err[3]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    function automatic logic [63:0] rdata(input int unsigned k);
        case (k)
            0:       return {32'h0, rd0};
            1:       return {32'h0, rd1};
            2:       return {32'h0, rd2};
            default: return rd3;
        endcase
    endfunction

    // Entered and left at posedge+1; PSEL stays high afterwards so a following
    // call gives a back-to-back setup.
    task automatic xfer(input int unsigned k, input logic wr, input logic [31:0] addr,
                        input logic [63:0] wd, input logic [7:0] strb, input logic [2:0] prot,
                        input int unsigned exp_ws, input logic exp_err,
                        input logic [63:0] exp_rd, input string tag);
        int unsigned n = 0;
        psel = '0; psel[k] = 1'b1; penable = 1'b0;
        pwrite = wr; paddr = addr; pwdata = wd; pstrb = strb; pprot = prot;
        @(posedge clk); #1;
        penable = 1'b1;
        while (!rdy[k] && n < 20) begin
            pwdata = ~pwdata;
            n++;
            @(posedge clk); #1;
        end
        check({tag, "_wait"}, 64'(n), 64'(exp_ws));
        check({tag, "_err"}, {63'h0, err[k]}, {63'h0, exp_err});
        check({tag, "_rd"}, rdata(k), exp_rd);
        @(posedge clk); #1;
        check({tag, "_pulse"}, {63'h0, rdy[k]}, 64'h0);
    endtask

    task automatic idle(input int unsigned cycles);
        psel = '0; penable = 1'b0;
        repeat (cycles) @(posedge clk);
        #1;
    endtask

    initial begin
        rstn = '0; psel = '0; penable = 1'b0; pwrite = 1'b0; pprot = 3'b000;
        paddr = '0; pwdata = '0; pstrb = '0;
        repeat (2) @(posedge clk);
        #1;
        for (int k = 0; k < 4; k++) begin
            check("rst_rdy", {60'h0, rdy}, 64'h0);
            check("rst_err", {60'h0, err}, 64'h0);
            check("rst_rd", rdata(k), 64'h0);
        end
        rstn = '1;
        @(posedge clk); #1;

        // zero wait states: write/read, partial strobes, error cases
        xfer(0, 1, 32'h3010, 64'hDEADBEEF, 8'hF, 3'b000, 0, 0, 64'h0, "w0_wr");
        xfer(0, 0, 32'h3010, 64'h0, 8'h0, 3'b000, 0, 0, 64'hDEADBEEF, "w0_rd");
        xfer(0, 1, 32'h3010, 64'h11223344, 8'h5, 3'b000, 0, 0, 64'h0, "w0_part");
        xfer(0, 0, 32'h3010, 64'h0, 8'h0, 3'b000, 0, 0, 64'hDE22BE44, "w0_partrd");
        xfer(0, 1, 32'h2FFC, 64'hFFFFFFFF, 8'hF, 3'b000, 0, 1, 64'h0, "w0_below");
        xfer(0, 1, 32'h3002, 64'hFFFFFFFF, 8'hF, 3'b000, 0, 1, 64'h0, "w0_misal");
        xfer(0, 0, 32'h3000, 64'h0, 8'h0, 3'b000, 0, 0, 64'h0, "w0_unchg");
        xfer(0, 0, 32'h3010, 64'h0, 8'h1, 3'b000, 0, 1, 64'h0, "w0_rdstrb");
        xfer(0, 1, 32'h3FFC, 64'h0BADF00D, 8'hF, 3'b000, 0, 0, 64'h0, "w0_top");
        xfer(0, 0, 32'h3FFC, 64'h0, 8'h0, 3'b000, 0, 0, 64'h0BADF00D, "w0_toprd");
        xfer(0, 1, 32'h4000, 64'h1, 8'hF, 3'b000, 0, 1, 64'h0, "w0_above");
        xfer(0, 0, 32'h3010, 64'h0, 8'h0, 3'b000, 0, 0, 64'hDE22BE44, "w0_final");

        // PENABLE high in IDLE with no setup is ignored
        psel = 4'b0001; penable = 1'b1; pwrite = 1'b1; paddr = 32'h3010; pstrb = 8'hF;
        repeat (3) begin
            @(posedge clk); #1;
            check("w0_noset", {63'h0, rdy[0]}, 64'h0);
        end
        idle(1);
        xfer(0, 0, 32'h3010, 64'h0, 8'h0, 3'b000, 0, 0, 64'hDE22BE44, "w0_noset_rd");
        idle(1);

        // three wait states; PWDATA toggles during waits
        xfer(1, 1, 32'h3000, 64'hA5A5A5A5, 8'hF, 3'b000, 3, 0, 64'h0, "w3_wr");
        xfer(1, 0, 32'h3000, 64'h0, 8'h0, 3'b000, 3, 0, 64'hA5A5A5A5, "w3_rd");

        // reset during the access phase of a write
        psel = 4'b0010; penable = 1'b0; pwrite = 1'b1; paddr = 32'h3008;
        pwdata = 64'h55AA55AA; pstrb = 8'hF;
        @(posedge clk); #1;
        penable = 1'b1;
        @(posedge clk); #1;
        rstn[1] = 1'b0; psel = '0; penable = 1'b0;
        @(posedge clk); #1;
        check("w3_rst_rdy", {63'h0, rdy[1]}, 64'h0);
        check("w3_rst_err", {63'h0, err[1]}, 64'h0);
        check("w3_rst_rd", rdata(1), 64'h0);
        rstn[1] = 1'b1;
        @(posedge clk); #1;
        xfer(1, 0, 32'h3008, 64'h0, 8'h0, 3'b000, 3, 0, 64'h0, "w3_drop");
        xfer(1, 0, 32'h3000, 64'h0, 8'h0, 3'b000, 3, 0, 64'h0, "w3_clr");
        idle(1);

        // secure-only, two wait states, abort
        xfer(2, 1, 32'h3004, 64'h12345678, 8'hF, 3'b000, 2, 0, 64'h0, "sec_wr");
        xfer(2, 1, 32'h3004, 64'hFFFFFFFF, 8'hF, 3'b010, 2, 1, 64'h0, "sec_ns");
        xfer(2, 0, 32'h3004, 64'h0, 8'h0, 3'b010, 2, 1, 64'h0, "sec_nsrd");
        xfer(2, 0, 32'h3004, 64'h0, 8'h0, 3'b101, 2, 0, 64'h12345678, "sec_rd");
        idle(1);
        psel = 4'b0100; penable = 1'b0; pwrite = 1'b1; paddr = 32'h3004;
        pwdata = 64'hCAFEF00D; pstrb = 8'hF; pprot = 3'b000;
        @(posedge clk); #1;
        penable = 1'b1;
        check("abort_acc", {63'h0, rdy[2]}, 64'h0);
        psel = '0; penable = 1'b0;
        repeat (4) begin
            @(posedge clk); #1;
            check("abort_idle", {63'h0, rdy[2]}, 64'h0);
        end
        xfer(2, 0, 32'h3004, 64'h0, 8'h0, 3'b000, 2, 0, 64'h12345678, "abort_rd");
        idle(1);

        // 64-bit data, 16 words
        xfer(3, 1, 32'h3078, 64'h0123456789ABCDEF, 8'hFF, 3'b000, 0, 0, 64'h0, "d64_wr");
        xfer(3, 0, 32'h3078, 64'h0, 8'h0, 3'b000, 0, 0, 64'h0123456789ABCDEF, "d64_rd");
        xfer(3, 0, 32'h3080, 64'h0, 8'h0, 3'b000, 0, 1, 64'h0, "d64_oob");
        xfer(3, 1, 32'h3074, 64'hFFFFFFFFFFFFFFFF, 8'hFF, 3'b000, 0, 1, 64'h0, "d64_misal");
        xfer(3, 0, 32'h3070, 64'h0, 8'h0, 3'b000, 0, 0, 64'h0, "d64_unchg");
        xfer(3, 0, 32'h3078, 64'h0, 8'h0, 3'b000, 0, 0, 64'h0123456789ABCDEF, "d64_rd2");
        idle(2);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
